// File: rtl/uart_tx_arbiter_if.sv
// Interface bundling the requester-side and transmitter-side signals of
// uart_tx_arbiter. The slave modport is the arbiter's view. The master
// modport is the view of the environment driving it.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BYTESIZES = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BYTESIZES-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_valid;
  logic [BYTESIZES-1:0]         tx_data;
  logic                         tx_done;
  logic [IW-1:0]                grant_id;
  logic                         busy;
  logic                         err_timeout;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_valid, tx_data, grant_id, busy, err_timeout
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_valid, tx_data, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX channel among
// NUM_REQ byte producers, with a valid/done handshake to the transmitter
// and a timeout that abandons a transfer whose tx_done never arrives.
// Optional macro UART_ARB_LOCK_EN: packet lock. The arbiter stays with
// one requester until that requester's req_last byte has been accepted.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BYTESIZES  = 8,
  parameter int TX_TIMEOUT = 100000
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TX_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TX_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_r;
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        grant_id_r;
  logic [CW-1:0]        cnt_r;
  logic                 tx_valid_r;
  logic [BYTESIZES-1:0] tx_data_r;
  logic                 busy_r;
  logic                 err_timeout_r;

  logic [NUM_REQ-1:0]   elig_s;
  logic                 found_s;
  logic [IW-1:0]        sel_s;
  logic [BYTESIZES-1:0] sel_byte_s;
  logic [NUM_REQ-1:0]   req_ready_s;

  // Index of the requester after i, wrapping NUM_REQ-1 back to 0.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IDX_LAST) ? {IW{1'b0}} : i + IW'(1);
  endfunction

  // One-hot vector with bit i set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = {NUM_REQ{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef UART_ARB_LOCK_EN
  logic lock_r;

  // While a packet is open, only its owner may compete for the channel.
  always_comb begin
    elig_s = bus.req_valid;
    if (lock_r) begin
      elig_s = bus.req_valid & onehot(grant_id_r);
    end else begin
      elig_s = bus.req_valid;
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = ^bus.req_last;

  // Without packet lock every pending requester is eligible.
  always_comb begin
    elig_s = bus.req_valid;
  end
`endif

  // Round-robin search. The first eligible requester found from ptr upward
  // (modulo NUM_REQ) wins.
  always_comb begin
    logic [IW-1:0] idx_v;
    found_s = 1'b0;
    sel_s   = ptr_r;
    idx_v   = ptr_r;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && elig_s[idx_v]) begin
        found_s = 1'b1;
        sel_s   = idx_v;
      end else begin
        found_s = found_s;
      end
      idx_v = next_idx(idx_v);
    end
  end

  assign sel_byte_s = bus.req_data[sel_s*BYTESIZES +: BYTESIZES];

  // Accept strobe depends only on registered state and req_valid. It has
  // no path from tx_done.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    if ((state_r == IDLE) && found_s) begin
      req_ready_s = onehot(sel_s);
    end else begin
      req_ready_s = {NUM_REQ{1'b0}};
    end
  end

  // Controller FSM: accept a byte in IDLE, hold it in BUSY until tx_done
  // arrives or the timeout expires.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      ptr_r         <= {IW{1'b0}};
      grant_id_r    <= {IW{1'b0}};
      cnt_r         <= {CW{1'b0}};
      tx_valid_r    <= 1'b0;
      tx_data_r     <= {BYTESIZES{1'b0}};
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_r        <= 1'b0;
`endif
    end else begin
      err_timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            tx_data_r  <= sel_byte_s;
            tx_valid_r <= 1'b1;
            grant_id_r <= sel_s;
            cnt_r      <= {CW{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= BUSY;
`ifdef UART_ARB_LOCK_EN
            if (bus.req_last[sel_s]) begin
              ptr_r  <= next_idx(sel_s);
              lock_r <= 1'b0;
            end else begin
              lock_r <= 1'b1;
            end
`else
            ptr_r      <= next_idx(sel_s);
`endif
          end
        end
        BUSY: begin
          if (bus.tx_done) begin
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            tx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            err_timeout_r <= 1'b1;
            state_r       <= IDLE;
`ifdef UART_ARB_LOCK_EN
            // An abort closes any open packet. The pointer moves past the owner.
            ptr_r  <= next_idx(grant_id_r);
            lock_r <= 1'b0;
`endif
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.tx_valid    = tx_valid_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.grant_id    = grant_id_r;
  assign bus.busy        = busy_r;
  assign bus.err_timeout = err_timeout_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// The main instance uses a long timeout and is checked by a scoreboard.
// The stimulus queues each expected byte and requester when the byte is
// issued. A monitor compares each rising tx_valid against that queue.
// A second instance with TX_TIMEOUT=8 covers the timeout boundary.
module tb_uart_tx_arbiter;
  logic clock;
  logic reset;

  uart_tx_arbiter_if #(.NUM_REQ(4), .BYTESIZES(8)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(4), .BYTESIZES(8)) bus_to ();

  uart_tx_arbiter #(.NUM_REQ(4), .BYTESIZES(8), .TX_TIMEOUT(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .BYTESIZES(8), .TX_TIMEOUT(8)) dut_to (
    .clock (clock),
    .reset (reset),
    .bus   (bus_to.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] gid;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   last_set_at = -1;
  logic prev_valid = 1'b0;

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.data = d;
    e.gid  = g;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) until tx_valid is high.
  task automatic wait_tx();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clock); #1;
      if (bus.tx_valid) seen = 1'b1;
    end
    if (!seen) check("tx_valid_wait", 32'd0, 32'd1);
  endtask

  // Serve n frames: tx_done comes gap cycles after each tx_valid rise.
  // Requests are dropped together with the last tx_done.
  task automatic serve(input int n, input int gap);
    for (int f = 0; f < n; f++) begin
      wait_tx();
      if (f == last_set_at) bus.req_last = 4'b1111;
      repeat (gap - 1) @(posedge clock);
      #1 bus.tx_done = 1'b1;
      if (f == n - 1) bus.req_valid = 4'b0000;
      @(posedge clock); #1 bus.tx_done = 1'b0;
    end
  endtask

  // Scoreboard monitor: each rising tx_valid must match the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.tx_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_tx_data", {24'd0, bus.tx_data}, {24'd0, e.data});
          check("sb_grant_id", {30'd0, bus.grant_id}, {30'd0, e.gid});
        end
      end
      prev_valid = bus.tx_valid;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic early;
    clock = 1'b0;
    reset = 1'b1;
    bus.req_valid = 4'b0000;    bus.req_data = 32'd0;    bus.req_last = 4'b0000;    bus.tx_done = 1'b0;
    bus_to.req_valid = 4'b0000; bus_to.req_data = 32'd0; bus_to.req_last = 4'b0000; bus_to.tx_done = 1'b0;

    // Reset for 3 cycles. All outputs are expected to be idle.
    repeat (3) @(posedge clock);
    #1;
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
    check("rst_grant_id", {30'd0, bus.grant_id}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_err_timeout", {31'd0, bus.err_timeout}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    reset = 1'b0;

    // All four requesters are valid. Round-robin order is A0, A1, A2, A3, A0.
    @(posedge clock); #1;
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req_valid = 4'b1111;
    push(8'hA0, 2'd0); push(8'hA1, 2'd1); push(8'hA2, 2'd2); push(8'hA3, 2'd3); push(8'hA0, 2'd0);
    serve(5, 20);

    // Only requester 2 is valid. Check the exact handshake timing.
    @(posedge clock); #1;
    bus.req_data  = {8'h00, 8'h55, 8'h00, 8'h00};
    bus.req_valid = 4'b0100;
    push(8'h55, 2'd2);
    #1 check("t3_ready_idle", {28'd0, bus.req_ready}, 32'h4);
    @(posedge clock); #1;
    check("t3_tx_valid_rise", {31'd0, bus.tx_valid}, 32'd1);
    check("t3_ready_busy", {28'd0, bus.req_ready}, 32'd0);
    check("t3_busy", {31'd0, bus.busy}, 32'd1);
    check("t3_grant_id", {30'd0, bus.grant_id}, 32'd2);
    repeat (3) @(posedge clock);
    #1 bus.tx_done = 1'b1;
    #1 check("t3_ready_during_done", {28'd0, bus.req_ready}, 32'd0);
    push(8'h55, 2'd2);
    @(posedge clock); #1 bus.tx_done = 1'b0;
    check("t3_tx_valid_fall", {31'd0, bus.tx_valid}, 32'd0);
    check("t3_busy_fall", {31'd0, bus.busy}, 32'd0);
    #1 check("t3_ready_again", {28'd0, bus.req_ready}, 32'h4);
    @(posedge clock); #1;
    check("t3_reaccept", {31'd0, bus.tx_valid}, 32'd1);
    bus.req_valid = 4'b0000;

    // Reset while busy. The pointer returns to 0.
    check("t5_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check("t5_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_grant_id", {30'd0, bus.grant_id}, 32'd0);
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req_valid = 4'b1111;
    #1 check("t5_ptr_zero", {28'd0, bus.req_ready}, 32'h1);
    push(8'hA0, 2'd0);
    serve(1, 20);

    // Requesters 1 and 0 compete. Requester 1 sends 3 bytes with last = 0, 0, 1.
    @(posedge clock); #1;
    bus.req_data  = {8'h00, 8'h00, 8'h11, 8'h10};
    bus.req_last  = 4'b0000;
    bus.req_valid = 4'b0011;
`ifdef UART_ARB_LOCK_EN
    push(8'h11, 2'd1); push(8'h11, 2'd1); push(8'h11, 2'd1); push(8'h10, 2'd0);
`else
    push(8'h11, 2'd1); push(8'h10, 2'd0); push(8'h11, 2'd1); push(8'h10, 2'd0);
`endif
    last_set_at = 1;
    serve(4, 5);
    last_set_at = -1;
    bus.req_last = 4'b0000;

    // Timeout with TX_TIMEOUT=8: err_timeout pulses 8 cycles after the tx_valid rise.
    @(posedge clock); #1;
    bus_to.req_data  = {8'h00, 8'h00, 8'h3C, 8'h5A};
    bus_to.req_valid = 4'b0010;
    @(posedge clock); #1;
    check("t4_tx_valid_rise", {31'd0, bus_to.tx_valid}, 32'd1);
    check("t4_tx_data", {24'd0, bus_to.tx_data}, 32'h3C);
    check("t4_grant_id", {30'd0, bus_to.grant_id}, 32'd1);
    bus_to.req_valid = 4'b0000;
    early = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(posedge clock); #1;
      if (bus_to.err_timeout || !bus_to.tx_valid) early = 1'b1;
    end
    check("t4_no_early_abort", {31'd0, early}, 32'd0);
    @(posedge clock); #1;
    check("t4_err_timeout", {31'd0, bus_to.err_timeout}, 32'd1);
    check("t4_tx_valid_drop", {31'd0, bus_to.tx_valid}, 32'd0);
    check("t4_busy_drop", {31'd0, bus_to.busy}, 32'd0);
    @(posedge clock); #1;
    check("t4_err_one_cycle", {31'd0, bus_to.err_timeout}, 32'd0);

    // After the abort the pointer has moved to 2, so requester 0 wins over 1.
    // tx_done on the final timeout cycle counts as done, with no error.
    bus_to.req_valid = 4'b0011;
    #1 check("t4_ptr_advanced", {28'd0, bus_to.req_ready}, 32'h1);
    @(posedge clock); #1;
    check("t4b_tx_data", {24'd0, bus_to.tx_data}, 32'h5A);
    bus_to.req_valid = 4'b0000;
    repeat (7) @(posedge clock);
    #1 bus_to.tx_done = 1'b1;
    @(posedge clock); #1 bus_to.tx_done = 1'b0;
    check("t4b_no_err", {31'd0, bus_to.err_timeout}, 32'd0);
    check("t4b_tx_valid_drop", {31'd0, bus_to.tx_valid}, 32'd0);

    repeat (3) @(posedge clock);
    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
